// File: rtl/activation_skew_feeder_pkg.sv
// Shared types and defaults for the activation skew feeder.
// Imported by the feeder top and its per-lane delay lines.
package activation_skew_feeder_pkg;

  localparam int DEFAULT_SYSTOLIC_SIZE    = 8;
  localparam int DEFAULT_ACTIVATION_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/activation_skew_feeder_delay.sv
// Per-lane {valid, data} shift chain feeding one row of the array.
// Invalid slots hold zero data so no stale value ever leaks out.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH:0] sr_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        sr_q[i] <= '0;
    end else begin
      sr_q[0] <= {valid_i, valid_i ? data_i : '0};
      for (int i = 1; i < DEPTH; i++)
        sr_q[i] <= sr_q[i-1];
    end
  end

  assign valid_o = sr_q[DEPTH-1][WIDTH];
  assign data_o  = valid_o ? sr_q[DEPTH-1][WIDTH-1:0] : '0;

endmodule

// File: rtl/activation_skew_feeder.sv
// Reads activation rows from memory and feeds them diagonally
// skewed into the west edge of the systolic array.
module activation_skew_feeder
  import activation_skew_feeder_pkg::*;
#(
  parameter int SYSTOLIC_SIZE    = DEFAULT_SYSTOLIC_SIZE,
  parameter int ACTIVATION_WIDTH = DEFAULT_ACTIVATION_WIDTH,
  parameter int ADDR_WIDTH       = $clog2(SYSTOLIC_SIZE),
  parameter int CNT_WIDTH        = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  vec_count,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] mem_rd_data,
  output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] act_out,
  output logic [SYSTOLIC_SIZE-1:0] act_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int W = ACTIVATION_WIDTH;
  localparam logic [CNT_WIDTH-1:0] S_CNT = CNT_WIDTH'(SYSTOLIC_SIZE);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic                 feed_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: begin
        if (start && vec_count != '0) begin
          n_d     = (vec_count > S_CNT) ? S_CNT : vec_count;
          cnt_d   = '0;
          state_d = FEED;
        end
      end
      FEED: begin
        if (cnt_q == n_q - ONE) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DRAIN: begin
        if (cnt_q == S_CNT - ONE) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign feed_v  = (state_q == FEED);
  assign rd_addr = feed_v ? cnt_q[ADDR_WIDTH-1:0] : '0;
  assign busy    = (state_q == FEED) || (state_q == DRAIN);
  assign done    = (state_q == DONE);

  // Lane k sits k+1 registers deep, producing the diagonal wavefront.
  for (genvar k = 0; k < SYSTOLIC_SIZE; k++) begin : g_lane
    skew_delay_line #(
      .DEPTH(k + 1),
      .WIDTH(W)
    ) u_line (
      .clk    (clk),
      .rst    (rst),
      .valid_i(feed_v),
      .data_i (mem_rd_data[k*W +: W]),
      .valid_o(act_valid[k]),
      .data_o (act_out[k*W +: W])
    );
  end

endmodule

// File: tb/tb_activation_skew_feeder.sv
// Scoreboard bench for activation_skew_feeder (S=8, W=8).
// Expected lane outputs are queued when a batch is accepted.
module tb_activation_skew_feeder;

  localparam int S  = 8;
  localparam int W  = 8;
  localparam int AW = 3;
  localparam int CW = 4;

  typedef struct {
    int         cyc;
    int         lane;
    logic [W-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [CW-1:0]   vec_count = '0;
  logic [AW-1:0]   rd_addr;
  logic [S*W-1:0]  mem_rd_data;
  logic [S*W-1:0]  act_out;
  logic [S-1:0]    act_valid;
  logic            busy;
  logic            done;

  logic [S*W-1:0]  mem [S];
  exp_t            q[$];
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  bit              have = 1'b0;
  int              b_cyc = 0;
  int              b_n = 0;

  activation_skew_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .vec_count  (vec_count),
    .rd_addr    (rd_addr),
    .mem_rd_data(mem_rd_data),
    .act_out    (act_out),
    .act_valid  (act_valid),
    .busy       (busy),
    .done       (done)
  );

  assign mem_rd_data = mem[rd_addr];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic load(input bit alt);
    for (int j = 0; j < S; j++)
      for (int k = 0; k < S; k++)
        mem[j][k*W +: W] = alt ? 8'((j*16 + k) ^ 8'hA5)
                               : 8'(j*16 + k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int vc);
    vec_count = CW'(vc);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Monitor: compare every cycle, then model start acceptance.
  always @(negedge clk) begin
    logic [S-1:0]   exp_v;
    logic [S*W-1:0] exp_a;
    bit             act;
    bit             e_busy;
    logic [AW-1:0]  e_addr;
    exp_t           e;
    if (rst) begin
      have = 1'b0;
      q.delete();
    end
    exp_v = '0;
    exp_a = '0;
    while (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      exp_v[e.lane] = 1'b1;
      exp_a[e.lane*W +: W] = e.data;
    end
    e_busy = have && cyc >= b_cyc + 1 && cyc <= b_cyc + b_n + S;
    e_addr = (have && cyc >= b_cyc + 1 && cyc <= b_cyc + b_n)
             ? AW'(cyc - b_cyc - 1) : '0;
    chk("act_valid", 64'(act_valid), 64'(exp_v));
    chk("act_out", act_out, exp_a);
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(have && cyc == b_cyc + b_n + S + 1));
    chk("rd_addr", 64'(rd_addr), 64'(e_addr));
    act = have && cyc <= b_cyc + b_n + S + 1;
    if (!rst && start && vec_count != 0 && !act) begin
      have  = 1'b1;
      b_cyc = cyc;
      b_n   = (vec_count > S) ? S : int'(vec_count);
      for (int d = 0; d < b_n + S - 1; d++)
        for (int k = 0; k < S; k++)
          if (d - k >= 0 && d - k < b_n)
            q.push_back('{cyc: cyc + 2 + d, lane: k,
                          data: mem[d-k][k*W +: W]});
    end
  end

  initial begin
    load(1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    pulse(8);
    repeat (20) tick();

    pulse(3);
    repeat (15) tick();

    pulse(0);
    repeat (3) tick();
    pulse(12);
    repeat (20) tick();

    // Start held through DONE, then a fresh batch right after.
    vec_count = 4'd4;
    start = 1'b1;
    repeat (14) tick();
    load(1'b1);
    vec_count = 4'd5;
    tick();
    start = 1'b0;
    repeat (20) tick();

    // Async reset between edges in the fourth FEED cycle.
    load(1'b0);
    pulse(8);
    repeat (3) tick();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_act_out", act_out, 64'd0);
    chk("rst_act_valid", 64'(act_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    repeat (2) tick();
    #2;
    rst = 1'b0;
    repeat (25) tick();

    chk("leftover", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/activation_skew_feeder.md
Name: activation_skew_feeder

Overview:
- Read-side companion to the activation memory.
- Reads activation rows from the memory through its address/data read port.
- Applies diagonal skew: lane k is delayed k extra cycles.
- Drives the skewed activations and per-lane valids into the west edge of the SYSTOLIC_SIZE x SYSTOLIC_SIZE array, with a start/busy/done handshake to the controller.

Parameters:
- SYSTOLIC_SIZE, 8, array dimension; lanes per row and rows in the memory.
- ACTIVATION_WIDTH, 8, bits per activation element.
- ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), memory address width.
- CNT_WIDTH, ADDR_WIDTH+1, width of the vector-count input.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to feed a batch; sampled only in IDLE.
- vec_count  input  CNT_WIDTH  number of rows to feed, starting at address 0; sampled with start.
- rd_addr  output  ADDR_WIDTH  memory read address.
- mem_rd_data  input  SYSTOLIC_SIZE*ACTIVATION_WIDTH  memory read data; combinational from rd_addr, same cycle.
- act_out  output  SYSTOLIC_SIZE*ACTIVATION_WIDTH  skewed activations; lane k = bits [k*W +: W].
- act_valid  output  SYSTOLIC_SIZE  per-lane valid.
- busy  output  1  high from first FEED cycle through last DRAIN cycle.
- done  output  1  one-cycle pulse after the last lane drains.

Behaviour:
- Reset (async, any state): state=IDLE, counters=0, all skew registers=0. rd_addr=0, act_out=0, act_valid=0, busy=0, done=0 immediately. An in-flight batch is discarded and does not resume.
- State machine:
  - IDLE: start=1 with 1<=vec_count<=SYSTOLIC_SIZE -> latch N=vec_count, go to FEED. vec_count > SYSTOLIC_SIZE is clamped to SYSTOLIC_SIZE. vec_count=0 -> start ignored, stay IDLE.
  - FEED: N cycles; rd_addr = 0,1,...,N-1. Each cycle's mem_rd_data enters the skew network with valid=1. Then go to DRAIN.
  - DRAIN: SYSTOLIC_SIZE cycles; zeros with valid=0 enter the skew network. Then go to DONE.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE. start is not accepted in this cycle.
- rd_addr=0 outside FEED.
- Timing: let cycle 0 be the IDLE cycle where start is sampled.
  - FEED occupies cycles 1..N; busy=1 in cycles 1..N+S.
  - Lane k of row j (read in cycle j+1) appears on act_out lane k with act_valid[k]=1 in cycle j+2+k. Lane 0 latency is 1 cycle after read; lane S-1 latency is S.
  - Last valid output is lane S-1 of row N-1, in cycle N+S. done is high in cycle N+S+1.
- Skew network: lane k is a registered shift chain of depth k+1 carrying {data, valid}. Lanes with valid=0 output data 0, never stale values.
- start while busy or in DONE: ignored, no queuing.
- No arithmetic on data; data passes through bit-exact.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, FEED, DRAIN, DONE.
  - Lane-slice helper constant ACTIVATION_WIDTH.
  - Common default SYSTOLIC_SIZE.
- One natural sub-module: skew_delay_line (params DEPTH, WIDTH). A {valid, data} shift register with async reset, instantiated per lane with DEPTH=k+1 via generate.

Test Plan:
- Full batch, S=8, W=8. Memory row j lane k = {j[3:0],k[3:0]}. start with vec_count=8 -> rd_addr 0..7 in cycles 1..8. act_out lane k = 8'h{j,k} in cycle j+2+k. busy in cycles 1..16, done in cycle 17 only.
- Partial batch, vec_count=3 -> rd_addr 0,1,2 only. act_valid[7] high in cycles 9..11. done in cycle 12. All invalid lanes read 0.
- vec_count=0 with start -> no busy, rd_addr stays 0, no done. vec_count=12 -> behaves exactly as vec_count=8.
- start held high through the batch and pulsed in the DONE cycle -> exactly one batch runs. A new start in the cycle after done starts the next batch, with FEED beginning one cycle later.
- rst asserted mid-FEED (cycle 4) asynchronously, between edges -> act_out, act_valid, busy, done go to 0 immediately. After release, no residual valids appear and no done pulse occurs.
- Back-to-back batches with different memory contents written between them -> second batch output is uncontaminated by first-batch data in every lane.
